// File: rtl/vga_tile_scan.sv
// Parametrised VGA scan generator with tile-memory addressing and paced update strobe.
// Optional define VGA_TILE_PREFETCH_EN issues re/raddr one clock ahead of each tile's first pixel.
module vga_tile_scan #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   TILE_W      = 20,
  parameter int   TILE_H      = 20,
  parameter logic SYNC_ACTIVE = 1'b0,
  localparam int  TX_W        = $clog2(H_ACTIVE / TILE_W),
  localparam int  TY_W        = $clog2(V_ACTIVE / TILE_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             next_duration,
  output logic [9:0]             hpos,
  output logic [9:0]             vpos,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic                   frame_start,
  output logic                   line_start,
  output logic                   re,
  output logic [TX_W+TY_W-1:0]   raddr,
  output logic                   updateoutput
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PX_W    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int LY_W    = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_ACT_M1 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
  localparam logic [LY_W-1:0] LY_LAST = LY_W'(TILE_H - 1);

  // h_q/v_q and the tile counters describe the pixel about to be presented;
  // every output is decoded from them and registered so it lines up with hpos/vpos.
  logic [9:0]           h_q, h_d, v_q, v_d;
  logic [PX_W-1:0]      px_q, px_d;
  logic [TX_W-1:0]      tx_q, tx_d;
  logic [LY_W-1:0]      ly_q, ly_d;
  logic [TY_W-1:0]      ty_q, ty_d;
  logic [9:0]           hpos_q, vpos_q;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 active_q, active_d, fs_q, fs_d, ls_q, ls_d;
  logic                 re_q, re_d, upd_q, upd_d;
  logic [TX_W+TY_W-1:0] raddr_q, raddr_d;
  logic [4:0]           duration_q, duration_d, dcnt_q, dcnt_d;
  logic                 h_last, v_last;

  always_comb begin
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    h_d    = h_last ? 10'd0 : h_q + 10'd1;
    v_d    = h_last ? (v_last ? 10'd0 : v_q + 10'd1) : v_q;

    px_d = px_q;
    tx_d = tx_q;
    if (h_last) begin
      px_d = '0;
      tx_d = '0;
    end else if (h_q < H_ACT_M1) begin
      if (px_q == PX_LAST) begin
        px_d = '0;
        tx_d = tx_q + TX_W'(1);
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end

    ly_d = ly_q;
    ty_d = ty_q;
    if (h_last) begin
      if (v_last) begin
        ly_d = '0;
        ty_d = '0;
      end else if (v_q < V_ACT_M1) begin
        if (ly_q == LY_LAST) begin
          ly_d = '0;
          ty_d = ty_q + TY_W'(1);
        end else begin
          ly_d = ly_q + LY_W'(1);
        end
      end
    end

    active_d = (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d  = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    ls_d     = (h_q == 10'd0);
    fs_d     = (h_q == 10'd0) && (v_q == 10'd0);

    re_d    = 1'b0;
    raddr_d = raddr_q;
`ifdef VGA_TILE_PREFETCH_EN
    // Look one pixel ahead: either the next tile on this line or tile 0 of the next line.
    if (v_q < V_ACT && h_q < H_ACT_M1 && px_q == PX_LAST) begin
      re_d    = 1'b1;
      raddr_d = {ty_q, tx_q + TX_W'(1)};
    end else if (h_last && v_d < V_ACT) begin
      re_d    = 1'b1;
      raddr_d = {ty_d, TX_W'(0)};
    end
`else
    if (active_d && px_q == '0) begin
      re_d    = 1'b1;
      raddr_d = {ty_q, tx_q};
    end
`endif

    duration_d = fs_d ? next_duration : duration_q;
    if (h_q == 10'd0) dcnt_d = 5'd0;
    else if (dcnt_q >= duration_q) dcnt_d = 5'd0;
    else dcnt_d = dcnt_q + 5'd1;
    upd_d = !active_d || (dcnt_d == 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      px_q       <= '0;
      tx_q       <= '0;
      ly_q       <= '0;
      ty_q       <= '0;
      hpos_q     <= '0;
      vpos_q     <= '0;
      hsync_q    <= ~SYNC_ACTIVE;
      vsync_q    <= ~SYNC_ACTIVE;
      active_q   <= 1'b0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      upd_q      <= 1'b1;
      duration_q <= '0;
      dcnt_q     <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      px_q       <= px_d;
      tx_q       <= tx_d;
      ly_q       <= ly_d;
      ty_q       <= ty_d;
      hpos_q     <= h_q;
      vpos_q     <= v_q;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      active_q   <= active_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
      re_q       <= re_d;
      raddr_q    <= raddr_d;
      upd_q      <= upd_d;
      duration_q <= duration_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign hpos         = hpos_q;
  assign vpos         = vpos_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign active       = active_q;
  assign frame_start  = fs_q;
  assign line_start   = ls_q;
  assign re           = re_q;
  assign raddr        = raddr_q;
  assign updateoutput = upd_q;

endmodule

// File: doc/vga_tile_scan.md
# vga_tile_scan

Parametrised VGA scan generator: successor to the fixed 640x480 controller. Produces horizontal/vertical pixel counters, sync pulses, active-video flag, frame/line strobes, a tile-memory read address with read enable, and the paced `updateoutput` strobe. Sits between the clock/reset logic and the tile BMEM plus pixel output stage. Timing, tile geometry and sync polarity are parameters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch
- TILE_W, 20, tile width in pixels; divides H_ACTIVE
- TILE_H, 20, tile height in lines; divides V_ACTIVE
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync
- Derived (localparam): H_TOTAL=sum of H_*, V_TOTAL=sum of V_*, TX_W=clog2(H_ACTIVE/TILE_W), TY_W=clog2(V_ACTIVE/TILE_H)

- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- next_duration  in  5  pixel-hold count, sampled at frame start
- hpos  out  10  horizontal counter, 0..H_TOTAL-1
- vpos  out  10  vertical counter, 0..V_TOTAL-1
- hsync, vsync  out  1  sync pulses at SYNC_ACTIVE level
- active  out  1  hpos<H_ACTIVE && vpos<V_ACTIVE
- frame_start  out  1  one-clock pulse at hpos=0, vpos=0
- line_start  out  1  one-clock pulse at hpos=0 of every line
- re  out  1  tile memory read enable
- raddr  out  TX_W+TY_W  {tile_y, tile_x}
- updateoutput  out  1  pixel-stage update strobe

## Operation
- hpos increments every clock, wraps H_TOTAL-1 -> 0; vpos increments on that wrap, wraps V_TOTAL-1 -> 0.
- hsync asserted for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise ~SYNC_ACTIVE.
- tile_x = hpos/TILE_W, tile_y = vpos/TILE_H via sub-tile counters (no dividers): pixel-in-tile counter 0..TILE_W-1 resets at line start; line-in-tile counter 0..TILE_H-1 resets at frame start.
- re pulses once per tile per active line (definition of cycle under Configuration); raddr holds the tile's address; outside those cycles raddr holds its last value, re=0.
- Duration: register `duration` loads next_duration at frame_start only. During active, an internal counter counts 0..duration and updateoutput pulses when it is 0; counter resets at each line start. duration=0 -> updateoutput=1 every active pixel. When !active, updateoutput=1.

## Timing
- Reset (async): hpos=0, vpos=0, duration=0, hsync=vsync=~SYNC_ACTIVE, active=0, frame_start=0, line_start=0, re=0, raddr=0, updateoutput=1.
- First clock edge after reset release: hpos=0, vpos=0 with frame_start=line_start=1, active=1 (counters in reset state already represent pixel 0,0; outputs registered and decoded from next count so every output is aligned with its hpos/vpos in the same cycle).
- Frame period exactly H_TOTAL*V_TOTAL clocks (420000 default); line period H_TOTAL (800).
- duration change mid-frame has no effect until next frame_start; value sampled at frame_start applies from that pixel.
- Reset asserted mid-line: all state returns to reset values immediately; no partial-sync glitch beyond the reset edge.
- Last visible line/pixel: no re for tile_y=V_ACTIVE/TILE_H or tile_x beyond last tile; raddr never exceeds {last tile_y, last tile_x}.

## Configuration
- VGA_TILE_PREFETCH_EN defined: re and raddr lead by one clock — asserted on the cycle before the tile's first pixel (for tile_x=0 that is hpos=H_TOTAL-1 of the preceding line, vpos one less or V_TOTAL-1 for line 0), so a 1-cycle BMEM delivers data on the first pixel.
- Undefined: re asserted on the tile's first pixel cycle itself (pixel-in-tile=0 during active); consumer absorbs memory latency.

## Test plan
- Reset then run 800 clocks -> hsync low exactly for hpos 656..751, line_start at hpos 0 only, active for hpos 0..639 on vpos 0.
- Run full frame -> vsync low for vpos 490..491 only; frame_start again after exactly 420000 clocks.
- Prefetch defined, line vpos=20 -> re at hpos 799 of vpos 19 with raddr={1,0}, then hpos 19,39,...,619 with tile_x 1..31; no re at hpos 639.
- Prefetch undefined -> re at hpos 0,20,...,620 with matching raddr; none during blanking.
- next_duration=3 held, change to 0 mid-frame -> updateoutput every 4th active pixel from hpos 0 until next frame_start, then every pixel; 1 throughout blanking.
- Assert reset at hpos=400, vpos=200 for 2 clocks -> all outputs at reset values; after release, frame_start at next edge with hpos=0, vpos=0.
